uart_rx: RTL and testbench

- Asynchronous serial receiver, 8N1 framing: 1 start bit (low), 8 data bits LSB-first, 1 stop bit (high). Idle line is high.
- Samples the serial line at bit centres and presents each received byte with a one-cycle valid strobe.
- Flags frames whose stop bit is low.
- Sits between the board RX pin and the sensor command/data path; one clock domain.

---
 rtl/uart_pkg.sv | 5 +
 rtl/sync_2ff.sv | 14 +
 rtl/uart_rx.sv | 88 ++++++++
 tb/tb_uart_rx.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and frame geometry
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_rx_state_t;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk)
    if (rst) {q, meta} <= {2{RESET_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver sampling at bit centres, with valid and frame-error strobes
module uart_rx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err
);
  import uart_pkg::*;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  uart_rx_state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [IW-1:0] bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic rx_s, fire, valid_n, frame_err_n;
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .rst(rst_n), .d(rx), .q(rx_s));
  always_ff @(posedge clk)
    if (rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      out_data  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      out_data  <= valid_n ? shift[7:0] : out_data;
      valid     <= valid_n;
      frame_err <= frame_err_n;
    end
  // START is skipped when the half-bit delay rounds to zero
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n   = (HALF == 16'd0) ? DATA : START;
          cnt_n     = (HALF == 16'd0) ? 16'd0 : 16'd1;
          bit_idx_n = '0;
        end
      end
      START:
        if (cnt == HALF) begin
          state_n   = rx_s ? IDLE : DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
        end
      DATA:
        if (cnt == LAST) begin
          shift_n[bit_idx] = rx_s;
          cnt_n            = '0;
          bit_idx_n        = bit_idx + 1'b1;
          state_n          = (bit_idx == IW'(DATA_BITS - 1)) ? STOP : DATA;
        end
      STOP:
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : WAIT_HIGH;
        end
      WAIT_HIGH: begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : WAIT_HIGH;
      end
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    fire        = (state == STOP) && (cnt == LAST);
    valid_n     = fire && rx_s;
    frame_err_n = fire && !rx_s;
    busy        = (state == START) || (state == DATA) || (state == STOP);
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench driving two receivers (1 and 16 clocks per bit) from a frame-level model
module tb_uart_rx;
  typedef struct {
    logic       err;
    logic [7:0] data;
  } evt_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx1 = 1'b1, rx16 = 1'b1;
  logic [7:0] d1, d16;
  logic v1, v16, b1, b16, e1, e16;
  evt_t q1[$], q16[$];
  logic [7:0] last1 = 8'h00, last16 = 8'h00;
  int tests = 0, fails = 0;
  int cyc = 0, stop_cyc1 = 0, v_cyc1 = 0, bcnt1 = 0;
  uart_rx #(.CLKS_PER_BIT(1)) u1 (.clk(clk), .rst_n(rst_n), .rx(rx1), .out_data(d1),
    .valid(v1), .busy(b1), .frame_err(e1));
  uart_rx #(.CLKS_PER_BIT(16)) u16 (.clk(clk), .rst_n(rst_n), .rx(rx16), .out_data(d16),
    .valid(v16), .busy(b16), .frame_err(e16));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic mon(input int sel, input logic v, input logic e, input logic [7:0] d);
    evt_t x;
    if (!(v || e)) return;
    chk($sformatf("exclusive%0d", sel), {31'd0, v && e}, 32'd0);
    if ((sel == 1) ? (q1.size() == 0) : (q16.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL unexpected%0d: got valid=%0b err=%0b data=%0h expected no output", sel, v, e, d);
      return;
    end
    if (sel == 1) x = q1.pop_front();
    else x = q16.pop_front();
    chk($sformatf("kind%0d", sel), {31'd0, e}, {31'd0, x.err});
    chk($sformatf("data%0d", sel), {24'd0, d}, {24'd0, x.data});
  endtask
  always @(negedge clk)
    if (!rst_n) begin
      mon(1, v1, e1, d1);
      mon(16, v16, e16, d16);
      if (v1) v_cyc1 = cyc;
      if (b1) bcnt1++;
    end
  task automatic drive_bit(input int sel, input logic b);
    if (sel == 1) begin
      rx1 = b;
      @(negedge clk);
    end else begin
      rx16 = b;
      repeat (16) @(negedge clk);
    end
  endtask
  task automatic expect_frame(input int sel, input logic [7:0] d, input logic stop);
    evt_t x;
    x.err  = !stop;
    x.data = stop ? d : ((sel == 1) ? last1 : last16);
    if (sel == 1) begin
      q1.push_back(x);
      last1 = x.data;
    end else begin
      q16.push_back(x);
      last16 = x.data;
    end
  endtask
  task automatic send(input int sel, input logic [7:0] d, input logic stop, input int gap);
    expect_frame(sel, d, stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (sel == 1) stop_cyc1 = cyc;
    drive_bit(sel, stop);
    for (int i = 0; i < gap; i++) drive_bit(sel, 1'b1);
  endtask
  task automatic idle(input int sel, input int n);
    for (int i = 0; i < n; i++) drive_bit(sel, 1'b1);
  endtask
  initial begin
    int b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    chk("rst_data", {24'd0, d1}, 32'h00);
    chk("rst_valid", {31'd0, v1}, 32'd0);
    chk("rst_busy", {31'd0, b1}, 32'd0);
    chk("rst_err", {31'd0, e1}, 32'd0);
    chk("rst_busy16", {31'd0, b16}, 32'd0);
    idle(1, 2);
    b0 = bcnt1;
    send(1, 8'h55, 1'b1, 0);
    idle(1, 4);
    chk("latency", stop_cyc1 > 0 ? v_cyc1 - stop_cyc1 : 0, 3);
    chk("busy_len", bcnt1 - b0, 9);
    send(1, 8'hB4, 1'b1, 4);
    send(1, 8'hA5, 1'b0, 2);
    chk("held_data", {24'd0, d1}, 32'hB4);
    expect_frame(1, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) drive_bit(1, 1'b0);
    idle(1, 3);
    send(1, 8'h12, 1'b1, 0);
    send(1, 8'h34, 1'b1, 3);
    rx16 = 1'b0;
    repeat (3) @(negedge clk);
    rx16 = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy", {31'd0, b16}, 32'd0);
    send(16, 8'h3C, 1'b1, 2);
    chk("data16", {24'd0, d16}, 32'h3C);
    drive_bit(1, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rx1 = 1'b1;
    rst_n = 1'b0;
    last1 = 8'h00;
    last16 = 8'h00;
    chk("abort_data", {24'd0, d1}, 32'h00);
    idle(1, 6);
    chk("abort_busy", {31'd0, b1}, 32'd0);
    send(1, 8'h7E, 1'b1, 4);
    chk("after_abort", {24'd0, d1}, 32'h7E);
    fork
      for (int n = 0; n < 200; n++) begin
        logic s;
        s = ($urandom_range(0, 9) != 0);
        send(1, 8'($urandom), s, s ? $urandom_range(0, 2) : $urandom_range(1, 2));
      end
      for (int n = 0; n < 16; n++) begin
        logic s;
        s = ($urandom_range(0, 9) != 0);
        send(16, 8'($urandom), s, s ? $urandom_range(0, 2) : $urandom_range(1, 2));
      end
    join
    repeat (100) @(negedge clk);
    chk("drain1", q1.size(), 0);
    chk("drain16", q16.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
